sweep_controller: RTL
=====================

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 Parameter: WIDTH, 3, counter/bound width in bits.
REQ-002 Parameter: DWELL, 2, hold cycles at each end point; legal range 0..7.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  begin a sweep run; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminate the run in progress.
REQ-007 Port: lo  input  WIDTH  lower sweep bound; captured on accepted start.
REQ-008 Port: hi  input  WIDTH  upper sweep bound; captured on accepted start.
REQ-009 Port: n_sweeps  input  4  number of full up/down sweeps; captured on accepted start.
REQ-010 Port: Q  output  WIDTH  counter value.
REQ-011 Port: up_down  output  1  current direction: 1 up (UP/TOP), 0 down (DOWN/BOT/IDLE/DONE).
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle pulse on normal run completion.
REQ-014 Port: aborted  output  1  one-cycle pulse when abort ends a run.
REQ-015 Port: cfg_err  output  1  one-cycle pulse when start is rejected.
REQ-016 Port: sweep_cnt  output  4  completed sweeps in current/last run.

Function
REQ-017 The FSM SHALL have states IDLE, UP, TOP, DOWN, BOT, DONE.
REQ-018 IDLE: start with lo<hi and n_sweeps!=0 SHALL capture lo/hi/n_sweeps, load Q<=lo, clear sweep_cnt, go UP.
REQ-019 IDLE: start with lo>=hi or n_sweeps==0 SHALL pulse cfg_err next cycle, stay IDLE, leave Q unchanged.
REQ-020 UP: Q!=hi_r -> Q<=Q+1; Q==hi_r -> TOP with dwell counter cleared (DOWN directly if DWELL==0).
REQ-021 TOP: Q held; after DWELL cycles in TOP -> DOWN.
REQ-022 DOWN: Q!=lo_r -> Q<=Q-1; Q==lo_r -> sweep_cnt<=sweep_cnt+1, then DONE if sweep_cnt+1==n_sweeps_r, else BOT (UP directly if DWELL==0).
REQ-023 BOT: Q held; after DWELL cycles in BOT -> UP.
REQ-024 DONE: done=1 for exactly this one cycle, Q held, next state IDLE.
REQ-025 Q SHALL stay within [lo_r, hi_r] during a run and SHALL never wrap.
REQ-026 abort in UP/TOP/DOWN/BOT SHALL force IDLE next cycle, pulse aborted, hold Q and sweep_cnt, suppress done.
REQ-027 abort has priority over any same-cycle transition; abort in IDLE or DONE SHALL be ignored (DONE still completes).
REQ-028 start while busy SHALL be ignored; changes to lo/hi/n_sweeps during a run SHALL have no effect.
REQ-029 start and abort together in IDLE: start SHALL be processed, abort ignored.

Reset
REQ-030 reset SHALL override all inputs on the clock edge it is sampled.
REQ-031 Reset values: state IDLE, Q=0, sweep_cnt=0, captured registers 0, busy/done/aborted/cfg_err=0, up_down=0.
REQ-032 reset mid-run SHALL abandon the run without a done or aborted pulse.

Structure
REQ-033 Package sweep_pkg SHALL hold the state enum, WIDTH default, DWELL default and dwell counter width.
REQ-034 Sub-module updown_counter_ld SHALL implement Q: synchronous reset to 0, load, enable, direction; controller drives load/en/up_down only.
REQ-035 Total RTL SHALL be a single FSM plus the counter sub-module; no combinational path from inputs to outputs.

Verification
REQ-036 lo=1, hi=3, n_sweeps=1, DWELL=2, start pulse -> Q per cycle 1,2,3,3,3,3,2,1,1; done high on the 9th cycle after start, sweep_cnt=1.
REQ-037 lo=0, hi=7, n_sweeps=2 -> Q reaches 7 twice and 0 three times, never wraps; done once, sweep_cnt=2.
REQ-038 lo=5, hi=5 start; then lo=2, hi=4, n_sweeps=0 start -> cfg_err pulse each time, busy stays 0, Q unchanged.
REQ-039 lo=0, hi=6, n_sweeps=3, abort when Q=4 in DOWN of sweep 2 -> next cycle IDLE, aborted=1, Q=4, sweep_cnt=1, no done.
REQ-040 Assert reset while in TOP -> next cycle Q=0, busy=0, no pulses; a new start then runs normally.
REQ-041 DWELL=0, lo=2, hi=3, n_sweeps=2 -> Q sequence 2,3,3,2,2,3,3,2 and then DONE with Q=2; TOP/BOT never entered.

Source files
------------

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sweep_pkg
// Brief    : Shared state encoding and default sizes for the sweep controller.
// Revision : 1.0
// ============================================================================
package sweep_pkg;

  localparam int WIDTH_DEFAULT = 3;
  localparam int DWELL_DEFAULT = 2;
  localparam int DWELL_W       = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_TOP  = 3'd2,
    S_DOWN = 3'd3,
    S_BOT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/updown_counter_ld.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_ld
// Brief    : Loadable up/down counter with enable and synchronous reset.
// Revision : 1.0
// ============================================================================
module updown_counter_ld #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up_down ? (q + WIDTH'(1)) : (q - WIDTH'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : sweep_controller
// Brief    : Runs n up/down sweeps of a counter between captured bounds, with
//            dwell at both end points, abort and configuration checking.
// Revision : 1.0
// ============================================================================
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [3:0]       n_sweeps,
  output logic [WIDTH-1:0] Q,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [3:0]       sweep_cnt
);

  // Last dwell count value before leaving an end point.
  localparam logic [DWELL_W-1:0] c_DWELL_LAST =
    (DWELL == 0) ? '0 : DWELL_W'(DWELL - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [3:0]         r_n_sweeps;
  logic [3:0]         r_sweep_cnt;
  logic [3:0]         w_sweep_inc;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_aborted;
  logic               r_cfg_err;
  logic               w_cfg_ok;
  logic               w_in_run;
  logic               w_at_hi;
  logic               w_at_lo;
  logic               w_dwell_end;
  logic               w_load;
  logic               w_en;
  logic               w_up;

  assign w_cfg_ok    = (lo < hi) && (n_sweeps != 4'd0);
  assign w_in_run    = (r_state == S_UP) || (r_state == S_TOP) ||
                       (r_state == S_DOWN) || (r_state == S_BOT);
  assign w_at_hi     = (Q == r_hi);
  assign w_at_lo     = (Q == r_lo);
  assign w_dwell_end = (r_dwell_cnt == c_DWELL_LAST);
  assign w_sweep_inc = r_sweep_cnt + 4'd1;
  assign w_up        = (r_state == S_UP) || (r_state == S_TOP);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_cfg_ok) begin
          w_state_nxt = S_UP;
          w_load      = 1'b1;
        end
      end
      S_UP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_at_hi) begin
          w_state_nxt = (DWELL == 0) ? S_DOWN : S_TOP;
        end else begin
          w_en = 1'b1;
        end
      end
      S_TOP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_dwell_end) begin
          w_state_nxt = S_DOWN;
        end
      end
      S_DOWN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_at_lo) begin
          if (w_sweep_inc == r_n_sweeps) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = (DWELL == 0) ? S_UP : S_BOT;
          end
        end else begin
          w_en = 1'b1;
        end
      end
      S_BOT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_dwell_end) begin
          w_state_nxt = S_UP;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_n_sweeps  <= '0;
      r_sweep_cnt <= '0;
      r_dwell_cnt <= '0;
      r_aborted   <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aborted <= abort && w_in_run;
      r_cfg_err <= (r_state == S_IDLE) && start && !w_cfg_ok;
      if (w_load) begin
        r_lo        <= lo;
        r_hi        <= hi;
        r_n_sweeps  <= n_sweeps;
        r_sweep_cnt <= '0;
      end else if ((r_state == S_DOWN) && !abort && w_at_lo) begin
        r_sweep_cnt <= w_sweep_inc;
      end
      // Dwell counter restarts whenever the state changes.
      if ((w_state_nxt == r_state) && ((r_state == S_TOP) || (r_state == S_BOT))) begin
        r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
      end else begin
        r_dwell_cnt <= '0;
      end
    end
  end

  updown_counter_ld #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .en      (w_en),
    .up_down (w_up),
    .d       (lo),
    .q       (Q)
  );

  assign up_down   = w_up;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign aborted   = r_aborted;
  assign cfg_err   = r_cfg_err;
  assign sweep_cnt = r_sweep_cnt;

endmodule
`default_nettype wire
